reg_dump_tx: RTL and testbench
==============================

REG_DUMP_TX -- requirements
Module: reg_dump_tx

Interface
REQ-001 SHALL provide parameter SENTINEL, default 32'h0000C0DE, the watched-register value that ends the test run.
REQ-002 SHALL provide parameter TIMEOUT, default 50, the run length in clock cycles before a forced dump (legal range 1..65535).
REQ-003 SHALL provide port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL provide port watch_data  input  32  the live value of register x11 from the CPU.
REQ-006 SHALL provide port cpu_halt  output  1  freezes the CPU pipeline and register-file writes while high.
REQ-007 SHALL provide port rd_addr  output  5  register-file read address (x0..x31).
REQ-008 SHALL provide port rd_data  input  32  register-file read data, combinational from rd_addr.
REQ-009 SHALL provide port dump_valid  output  1  a dump word is presented.
REQ-010 SHALL provide port dump_ready  input  1  the consumer accepts the word this cycle.
REQ-011 SHALL provide port dump_data  output  32  register value being sent.
REQ-012 SHALL provide port dump_idx  output  5  register index of dump_data.
REQ-013 SHALL provide port dump_last  output  1  high with dump_valid when dump_idx = 31.
REQ-014 SHALL provide port timed_out  output  1  the dump was forced by TIMEOUT, not by SENTINEL.
REQ-015 SHALL provide port done  output  1  all 32 words have been accepted.

Function
REQ-016 SHALL implement four states: WATCH, LOAD, SEND, DONE.
REQ-017 In WATCH, SHALL increment a 16-bit cycle counter each cycle, saturating at 65535.
REQ-018 In WATCH, SHALL go to LOAD with timed_out=0 when watch_data == SENTINEL.
REQ-019 In WATCH, SHALL go to LOAD with timed_out=1 when the counter equals TIMEOUT-1 and watch_data != SENTINEL.
REQ-020 SHALL give the sentinel priority when the sentinel match and the timeout occur in the same cycle (timed_out=0).
REQ-021 SHALL assert cpu_halt (registered) from the first cycle after leaving WATCH, and hold it through LOAD, SEND and DONE.
REQ-022 SHALL drive rd_addr = dump_idx at all times.
REQ-023 In LOAD, SHALL register rd_data into dump_data, set dump_valid=1 and go to SEND.
REQ-024 In SEND, SHALL hold dump_valid, dump_data, dump_idx and dump_last stable until dump_valid && dump_ready.
REQ-025 On acceptance with dump_idx < 31, SHALL increment dump_idx, clear dump_valid and go to LOAD.
REQ-026 On acceptance with dump_idx = 31, SHALL clear dump_valid, set done=1 and go to DONE.
REQ-027 SHALL ignore dump_ready whenever dump_valid is low.
REQ-028 SHALL make DONE terminal until reset, with dump_valid=0 and done=1.
REQ-029 Latency: sentinel sampled at edge N -> cpu_halt high after edge N, first dump_valid high after edge N+1; with dump_ready tied high, a full dump takes 64 cycles.
REQ-030 SHALL send x0 exactly as read (the register file supplies zero).

Reset
REQ-031 Reset SHALL force WATCH state, counter=0, dump_idx=0, rd_addr=0, dump_data=0, and dump_valid, dump_last, cpu_halt, timed_out and done all 0.
REQ-032 Reset asserted mid-dump SHALL abort the dump immediately and release cpu_halt; after release, operation restarts in WATCH with the counter at 0.

Verification
REQ-033 Sentinel path: x11 set to 0000C0DE at cycle 10, registers xi = i*0x11, dump_ready=1 -> cpu_halt at cycle 11, 32 words with idx 0..31 and data i*0x11, dump_last only on idx 31, timed_out=0, done after 64 cycles.
REQ-034 Timeout path: TIMEOUT=50, x11 never matches -> LOAD entered at counter 49, timed_out=1, full 32-word dump.
REQ-035 Backpressure: dump_ready low for 5 cycles during idx 7 -> dump_valid stays high, data/idx stay stable, no word lost or duplicated.
REQ-036 Simultaneous: sentinel matches on the same cycle as counter = TIMEOUT-1 -> timed_out=0.
REQ-037 Reset during SEND at idx 12 -> all outputs 0 next cycle, cpu_halt low; a later sentinel restarts the dump at idx 0.
REQ-038 Post-done: dump_ready toggled in DONE -> no further dump_valid, done stays 1.

Source files
------------

// File: rtl/reg_dump_tx.sv
// Watches x11 for a sentinel value (or a cycle timeout), then halts the CPU and
// streams all 32 register-file words out over a valid/ready port.
module reg_dump_tx #(
  parameter logic [31:0] SENTINEL = 32'h0000C0DE,
  parameter int unsigned TIMEOUT  = 50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] watch_data,
  output logic        cpu_halt,
  output logic [4:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [31:0] dump_data,
  output logic [4:0]  dump_idx,
  output logic        dump_last,
  output logic        timed_out,
  output logic        done
);

  typedef enum logic [1:0] {S_WATCH, S_LOAD, S_SEND, S_DONE} state_t;

  localparam logic [15:0] LAST_CYCLE = 16'(TIMEOUT - 1);

  state_t      state;
  logic [15:0] cycle_cnt;

  assign rd_addr = dump_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_WATCH;
      cycle_cnt  <= '0;
      cpu_halt   <= 1'b0;
      dump_valid <= 1'b0;
      dump_data  <= '0;
      dump_idx   <= '0;
      dump_last  <= 1'b0;
      timed_out  <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        S_WATCH: begin
          if (cycle_cnt != 16'hFFFF)
            cycle_cnt <= cycle_cnt + 16'd1;
          // Sentinel is tested first so a same-cycle timeout never flags timed_out.
          if (watch_data == SENTINEL) begin
            state     <= S_LOAD;
            cpu_halt  <= 1'b1;
            timed_out <= 1'b0;
          end else if (cycle_cnt == LAST_CYCLE) begin
            state     <= S_LOAD;
            cpu_halt  <= 1'b1;
            timed_out <= 1'b1;
          end
        end
        S_LOAD: begin
          dump_data  <= rd_data;
          dump_valid <= 1'b1;
          dump_last  <= (dump_idx == 5'd31);
          state      <= S_SEND;
        end
        S_SEND: begin
          if (dump_valid && dump_ready) begin
            dump_valid <= 1'b0;
            dump_last  <= 1'b0;
            if (dump_idx == 5'd31) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              dump_idx <= dump_idx + 5'd1;
              state    <= S_LOAD;
            end
          end
        end
        S_DONE: begin
          dump_valid <= 1'b0;
          done       <= 1'b1;
        end
        default: state <= S_WATCH;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_tx.sv
// Scoreboard bench for reg_dump_tx: expected words are queued when a dump is
// triggered and a negedge monitor pops and compares each accepted word.
module tb_reg_dump_tx;

  localparam logic [31:0] SENT = 32'h0000C0DE;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] watch_data;
  logic        cpu_halt;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        dump_valid;
  logic        dump_ready;
  logic [31:0] dump_data;
  logic [4:0]  dump_idx;
  logic        dump_last;
  logic        timed_out;
  logic        done;

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
    logic        last;
  } word_t;

  word_t expq[$];
  int    pass_cnt = 0;
  int    tot_cnt  = 0;

  reg_dump_tx #(.SENTINEL(SENT), .TIMEOUT(50)) dut (
    .clk(clk), .reset(reset), .watch_data(watch_data), .cpu_halt(cpu_halt),
    .rd_addr(rd_addr), .rd_data(rd_data), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_data(dump_data), .dump_idx(dump_idx),
    .dump_last(dump_last), .timed_out(timed_out), .done(done)
  );

  always #5 clk = ~clk;

  // Register file model: xi = i * 0x11, so x0 reads as zero.
  assign rd_data = 32'(rd_addr) * 32'h11;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: compare accepted words and check stability while stalled.
  logic  hold_prev = 1'b0;
  word_t hold_word;
  always @(negedge clk) begin
    word_t cur, e;
    cur = '{idx: dump_idx, data: dump_data, last: dump_last};
    if (reset) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("stall_valid", 64'(dump_valid), 64'd1);
        chk("stall_word", 64'(cur), 64'(hold_word));
      end
      hold_prev = dump_valid && !dump_ready;
      hold_word = cur;
      if (dump_valid && dump_ready) begin
        if (expq.size() == 0) begin
          chk("unexpected_word", 64'(cur), 64'd0);
        end else begin
          e = expq.pop_front();
          chk("dump_word", 64'(cur), 64'(e));
        end
      end
    end
  end

  task automatic push_dump();
    for (int unsigned i = 0; i < 32; i++)
      expq.push_back('{idx: 5'(i), data: 32'(i) * 32'h11, last: (i == 31)});
  endtask

  task automatic reset_dut();
    reset      = 1'b1;
    watch_data = '0;
    dump_ready = 1'b0;
    expq.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_halt"},  64'(cpu_halt),   64'd0);
    chk({tag, "_valid"}, 64'(dump_valid), 64'd0);
    chk({tag, "_idx"},   64'(dump_idx),   64'd0);
    chk({tag, "_addr"},  64'(rd_addr),    64'd0);
    chk({tag, "_data"},  64'(dump_data),  64'd0);
    chk({tag, "_last"},  64'(dump_last),  64'd0);
    chk({tag, "_tmo"},   64'(timed_out),  64'd0);
    chk({tag, "_done"},  64'(done),       64'd0);
  endtask

  // Runs the dump to completion; optional 5-cycle stall on idx 7.
  task automatic finish_dump(input bit bp, output int cyc);
    int stall = 0;
    cyc = 0;
    dump_ready = 1'b1;
    while (!done && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      if (bp && dump_valid && dump_idx == 5'd7 && stall < 5) begin
        dump_ready = 1'b0;
        stall++;
      end else begin
        dump_ready = 1'b1;
      end
    end
    chk("done_reached", 64'(done), 64'd1);
    @(negedge clk);
    chk("queue_empty", 64'(expq.size()), 64'd0);
  endtask

  initial begin
    int cyc;
    // Reset state
    reset = 1'b1; watch_data = '0; dump_ready = 1'b0;
    #2;
    check_zero("rst");
    reset_dut();

    // Sentinel path: sentinel sampled at the 11th edge after release
    repeat (10) @(posedge clk);
    #1 chk("sent_pre_halt", 64'(cpu_halt), 64'd0);
    watch_data = SENT;
    push_dump();
    @(posedge clk); #1;
    chk("sent_halt", 64'(cpu_halt), 64'd1);
    chk("sent_valid0", 64'(dump_valid), 64'd0);
    chk("sent_tmo", 64'(timed_out), 64'd0);
    finish_dump(1'b0, cyc);
    chk("sent_cycles", 64'(cyc), 64'd64);
    chk("sent_tmo_end", 64'(timed_out), 64'd0);

    // Post-done: toggling ready produces nothing
    for (int i = 0; i < 8; i++) begin
      dump_ready = ~dump_ready;
      @(posedge clk); #1;
      chk("post_valid", 64'(dump_valid), 64'd0);
      chk("post_done", 64'(done), 64'd1);
    end

    // Timeout path with backpressure on idx 7
    reset_dut();
    cyc = 0;
    while (!cpu_halt && cyc < 100) begin
      if (cyc == 49) push_dump();
      @(posedge clk); #1;
      cyc++;
    end
    chk("tmo_cycles", 64'(cyc), 64'd50);
    chk("tmo_flag", 64'(timed_out), 64'd1);
    finish_dump(1'b1, cyc);
    chk("tmo_flag_end", 64'(timed_out), 64'd1);

    // Simultaneous sentinel and timeout
    reset_dut();
    repeat (49) @(posedge clk);
    #1 chk("sim_pre_halt", 64'(cpu_halt), 64'd0);
    watch_data = SENT;
    push_dump();
    @(posedge clk); #1;
    chk("sim_halt", 64'(cpu_halt), 64'd1);
    chk("sim_tmo", 64'(timed_out), 64'd0);
    finish_dump(1'b0, cyc);

    // Reset during SEND at idx 12, then restart
    reset_dut();
    watch_data = SENT;
    push_dump();
    dump_ready = 1'b1;
    cyc = 0;
    while (!(dump_valid && dump_idx == 5'd12) && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("abort_reach12", 64'(dump_idx), 64'd12);
    dump_ready = 1'b0;
    reset = 1'b1;
    watch_data = '0;
    expq.delete();
    #1 chk("abort_async_halt", 64'(cpu_halt), 64'd0);
    @(posedge clk); #1;
    check_zero("abort");
    reset = 1'b0;
    watch_data = SENT;
    push_dump();
    @(posedge clk); #1;
    chk("restart_halt", 64'(cpu_halt), 64'd1);
    finish_dump(1'b0, cyc);
    chk("restart_cycles", 64'(cyc), 64'd64);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
